// File: rtl/isp_axi_pkg.sv
// Shared AXI constants, response/burst encodings and FSM state types
// for the picture DRAM responder.
package isp_axi_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 128;
  localparam int ID_W   = 4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_16B   = 3'b100;

  typedef enum logic [1:0] {
    R_IDLE,
    R_WAIT,
    R_BURST
  } rd_state_t;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } wr_state_t;

  // Only 16-byte INCR bursts are served; anything else is a slave error.
  function automatic logic bad_xfer(input logic [1:0] burst,
                                    input logic [2:0] size);
    return (burst != BURST_INCR) || (size != SIZE_16B);
  endfunction

endpackage

// File: rtl/dram_word_mem.sv
// Simple dual-port word memory: one write port, one synchronous read port.
// Ports: clk; we/waddr/wdata write; re/raddr/rdata read (read-first, q holds when re=0).
module dram_word_mem #(
  parameter int DEPTH  = 3072,
  parameter int DATA_W = isp_axi_pkg::DATA_W,
  parameter int AW     = 12
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
    if (we) mem[waddr] <= wdata;
  end

endmodule

// File: rtl/dram_axi_responder.sv
// AXI4 slave emulating the ISP picture DRAM from an internal word memory.
// Ports: clk/rst; AR+R read channel; AW+W+B write channel (one outstanding each).
module dram_axi_responder #(
  parameter int                ADDR_W    = isp_axi_pkg::ADDR_W,
  parameter int                DATA_W    = isp_axi_pkg::DATA_W,
  parameter int                ID_W      = isp_axi_pkg::ID_W,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 'h0001_0000,
  parameter int                DEPTH     = 3072,
  parameter int                RD_LAT    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ID_W-1:0]   arid,
  input  logic [ADDR_W-1:0] araddr,
  input  logic [7:0]        arlen,
  input  logic [2:0]        arsize,
  input  logic [1:0]        arburst,
  input  logic              arvalid,
  output logic              arready,
  output logic [ID_W-1:0]   rid,
  output logic [DATA_W-1:0] rdata,
  output logic [1:0]        rresp,
  output logic              rlast,
  output logic              rvalid,
  input  logic              rready,
  input  logic [ID_W-1:0]   awid,
  input  logic [ADDR_W-1:0] awaddr,
  input  logic [7:0]        awlen,
  input  logic [2:0]        awsize,
  input  logic [1:0]        awburst,
  input  logic              awvalid,
  output logic              awready,
  input  logic [DATA_W-1:0] wdata,
  input  logic              wlast,
  input  logic              wvalid,
  output logic              wready,
  output logic [ID_W-1:0]   bid,
  output logic [1:0]        bresp,
  output logic              bvalid,
  input  logic              bready
);
  import isp_axi_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(DEPTH);

  function automatic logic [ADDR_W-1:0] word_of(input logic [ADDR_W-1:0] a);
    return (a - BASE_ADDR) >> 4;
  endfunction

  // ---------------- read channel ----------------
  rd_state_t         r_state, r_next;
  logic [ID_W-1:0]   r_id;
  logic [ADDR_W-1:0] r_idx;
  logic [7:0]        r_len, r_beat;
  logic [3:0]        r_cnt;
  logic              r_bad, r_below;
  logic              ar_rdy, r_valid, r_last, r_zero;
  logic [1:0]        r_resp;
  logic              ar_fire, r_fire;
  logic [DATA_W-1:0] mem_q;

  // Beat about to be loaded into the output stage (prefetch path).
  logic              ld, ld_bad, ld_below, ld_oor;
  logic [ADDR_W-1:0] ld_idx, ld_word;
  logic [7:0]        ld_beat, ld_len;

  assign ar_fire = arvalid & ar_rdy;
  assign r_fire  = r_valid & rready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= R_IDLE;
    else     r_state <= r_next;
  end

  always_comb begin
    r_next = r_state;
    unique case (r_state)
      R_IDLE:  if (ar_fire) r_next = (RD_LAT == 0) ? R_BURST : R_WAIT;
      R_WAIT:  if (r_cnt == 4'd0) r_next = R_BURST;
      R_BURST: if (r_fire && r_last) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  always_comb begin
    ld       = 1'b0;
    ld_idx   = r_idx;
    ld_len   = r_len;
    ld_bad   = r_bad;
    ld_below = r_below;
    ld_beat  = 8'd0;
    unique case (r_state)
      R_IDLE: begin
        ld_idx   = word_of(araddr);
        ld_len   = arlen;
        ld_bad   = bad_xfer(arburst, arsize);
        ld_below = araddr < BASE_ADDR;
        ld       = ar_fire && (RD_LAT == 0);
      end
      R_WAIT:  ld = r_cnt == 4'd0;
      R_BURST: begin
        ld_beat = r_beat + 8'd1;
        ld      = r_fire && !r_last;
      end
      default: ;
    endcase
    ld_word = ld_idx + ADDR_W'(ld_beat);
    ld_oor  = ld_below || (ld_word >= LIMIT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ar_rdy  <= 1'b0;
      r_valid <= 1'b0;
      r_id    <= '0;
      r_idx   <= '0;
      r_len   <= '0;
      r_beat  <= '0;
      r_cnt   <= '0;
      r_bad   <= 1'b0;
      r_below <= 1'b0;
      r_last  <= 1'b0;
      r_zero  <= 1'b0;
      r_resp  <= RESP_OKAY;
    end else begin
      ar_rdy  <= r_next == R_IDLE;
      r_valid <= r_next == R_BURST;
      if (ar_fire) begin
        r_id    <= arid;
        r_idx   <= ld_idx;
        r_len   <= arlen;
        r_bad   <= ld_bad;
        r_below <= ld_below;
        r_cnt   <= 4'(RD_LAT - 1);
      end else if (r_state == R_WAIT) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (ld) begin
        r_beat <= ld_beat;
        r_last <= ld_beat == ld_len;
        r_zero <= ld_bad || ld_oor;
        r_resp <= ld_bad ? RESP_SLVERR :
                  ld_oor ? RESP_DECERR : RESP_OKAY;
      end
    end
  end

  // ---------------- write channel ----------------
  wr_state_t         w_state, w_next;
  logic [ID_W-1:0]   w_id;
  logic [ADDR_W-1:0] w_idx, w_word;
  logic [7:0]        w_len, w_beat;
  logic              w_bad, w_below, w_slv, w_dec, w_oor, w_end;
  logic              aw_rdy, w_rdy, b_vld;
  logic              aw_fire, w_fire, b_fire, mem_we;

  assign aw_fire = awvalid & aw_rdy;
  assign w_fire  = wvalid & w_rdy;
  assign b_fire  = b_vld & bready;
  assign w_word  = w_idx + ADDR_W'(w_beat);
  assign w_oor   = w_below || (w_word >= LIMIT);
  assign w_end   = w_beat == w_len;
  assign mem_we  = w_fire && !w_bad && !w_oor;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) w_state <= W_IDLE;
    else     w_state <= w_next;
  end

  always_comb begin
    w_next = w_state;
    unique case (w_state)
      W_IDLE:  if (aw_fire) w_next = W_DATA;
      W_DATA:  if (w_fire && w_end) w_next = W_RESP;
      W_RESP:  if (b_fire) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_rdy  <= 1'b0;
      w_rdy   <= 1'b0;
      b_vld   <= 1'b0;
      w_id    <= '0;
      w_idx   <= '0;
      w_len   <= '0;
      w_beat  <= '0;
      w_bad   <= 1'b0;
      w_below <= 1'b0;
      w_slv   <= 1'b0;
      w_dec   <= 1'b0;
    end else begin
      aw_rdy <= w_next == W_IDLE;
      w_rdy  <= w_next == W_DATA;
      b_vld  <= w_next == W_RESP;
      if (aw_fire) begin
        w_id    <= awid;
        w_idx   <= word_of(awaddr);
        w_len   <= awlen;
        w_beat  <= 8'd0;
        w_bad   <= bad_xfer(awburst, awsize);
        w_below <= awaddr < BASE_ADDR;
        w_slv   <= bad_xfer(awburst, awsize);
        w_dec   <= 1'b0;
      end else if (w_fire) begin
        w_beat <= w_beat + 8'd1;
        // wlast must mark exactly the final beat
        if (wlast != w_end) w_slv <= 1'b1;
        if (w_oor) w_dec <= 1'b1;
      end
    end
  end

  dram_word_mem #(
    .DEPTH (DEPTH),
    .DATA_W(DATA_W),
    .AW    (AW)
  ) u_mem (
    .clk  (clk),
    .we   (mem_we),
    .waddr(w_word[AW-1:0]),
    .wdata(wdata),
    .re   (ld && !ld_bad && !ld_oor),
    .raddr(ld_word[AW-1:0]),
    .rdata(mem_q)
  );

  // ---------------- outputs ----------------
  always_comb begin
    arready = ar_rdy;
    rvalid  = r_valid;
    rid     = r_id;
    rlast   = r_valid & r_last;
    rresp   = r_valid ? r_resp : RESP_OKAY;
    rdata   = (r_valid && !r_zero) ? mem_q : '0;
    awready = aw_rdy;
    wready  = w_rdy;
    bvalid  = b_vld;
    bid     = w_id;
    bresp   = !b_vld ? RESP_OKAY :
              w_slv  ? RESP_SLVERR :
              w_dec  ? RESP_DECERR : RESP_OKAY;
  end

endmodule

// File: doc/dram_axi_responder.md
# dram_axi_responder

Synthesizable AXI4 slave that emulates the picture DRAM seen by the ISP core: it answers the core's AXI read bursts (picture fetch) and write bursts (picture write-back) from an internal 128-bit word memory. It sits on the far side of the core's AXI master port, in place of the behavioural DRAM model, so core plus responder can run in FPGA or emulation. Read and write channels are independent; each accepts one outstanding transaction.

## Interface
- ADDR_W, 32, AXI address width
- DATA_W, 128, data width; one beat = 16 bytes
- ID_W, 4, AXI ID width
- BASE_ADDR, 32'h0001_0000, byte address of memory word 0
- DEPTH, 3072, number of 128-bit words (16 pictures × 3072 bytes)
- RD_LAT, 2, idle cycles between AR handshake and first R beat (0..15)
- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- arid/araddr/arlen/arsize/arburst  in  ID_W/ADDR_W/8/3/2  read address; arvalid in 1; arready out 1
- rid out ID_W; rdata out DATA_W; rresp out 2; rlast out 1; rvalid out 1; rready in 1
- awid/awaddr/awlen/awsize/awburst  in  ID_W/ADDR_W/8/3/2  write address; awvalid in 1; awready out 1
- wdata in DATA_W; wlast in 1; wvalid in 1; wready out 1
- bid out ID_W; bresp out 2; bvalid out 1; bready in 1

## Operation
- Reset: every output 0 (including arready/awready); memory contents not reset. First cycle after rst falls: arready=awready=1.
- Word index = (addr − BASE_ADDR) >> 4; address bits [3:0] ignored. Index computed in ADDR_W bits; addr < BASE_ADDR or index ≥ DEPTH is out of range.
- Only INCR (burst=2'b01), size 3'b100 supported; any other burst/size → whole transaction answered with SLVERR (2'b10), no memory access, rdata=0.
- Read FSM R_IDLE → R_WAIT → R_BURST → R_IDLE:
  - R_IDLE: arready=1; on arvalid&arready latch id, index, len; go R_WAIT (RD_LAT=0 → straight to R_BURST).
  - R_WAIT: 4-bit counter down to 0, arready=0.
  - R_BURST: rvalid=1, rdata=mem[index+beat], rresp OKAY(00) or DECERR(11) per beat if that beat's index out of range (rdata=0); rlast=1 on beat len. Beat advances only on rvalid&rready; rdata/rresp/rlast stable while stalled. After last handshake → R_IDLE.
- Write FSM W_IDLE → W_DATA → W_RESP → W_IDLE:
  - W_IDLE: awready=1; latch aw fields on handshake.
  - W_DATA: wready=1; each wvalid&wready writes wdata to mem[index+beat] if in range (else dropped, sticky DECERR). Burst ends after exactly len+1 beats regardless of wlast; wlast missing on final beat or present earlier → sticky SLVERR.
  - W_RESP: bvalid=1, bid latched, bresp = SLVERR if any protocol error, else DECERR if any dropped beat, else OKAY; held until bready.
- Same-cycle write and read of one word: read returns old value (read-first); write visible from next cycle.
- No 4 KB boundary checks; beat index wraps only via range check.
- rst asserted mid-burst: both FSMs to idle immediately, pending responses discarded, partially written beats remain in memory.

## Timing
- AR handshake in cycle T → first rvalid in cycle T+1+RD_LAT; with rready held high, one beat per cycle.
- AW handshake in T → wready high from T+1; last W handshake in T' → bvalid in T'+1; awready back high cycle after B handshake.
- arready/awready low whenever their FSM is not idle (single outstanding per channel).
- Outputs are registered; no combinational path from any input to any output.

## Structure
- Shared package isp_axi_pkg: DATA_W/ADDR_W/ID_W constants, resp codes (OKAY/SLVERR/DECERR), burst/size encodings, state enums for both FSMs.
- One sub-module: dram_word_mem, simple dual-port (1 write port, 1 synchronous read port, read-first) DEPTH×DATA_W; read FSM prefetches next beat so stalls never bubble.

## Test plan
- Write burst awaddr=0x0001_0000, awlen=3, wdata=0x…01..04, wlast on beat 4 → bvalid one cycle after beat 4, bresp=00, bid=awid.
- Read back araddr=0x0001_0000, arlen=3, RD_LAT=2, rready=1 → rvalid first at T+3, data 01,02,03,04, rlast only on beat 4, rresp=00.
- Same read with rready toggling 1,0,0,1 → rdata/rlast stable during stall, no beat lost or duplicated.
- araddr=0x0001_0000+16×3070, arlen=3 → beats 0–1 OKAY with data, beats 2–3 DECERR with rdata=0.
- Write awlen=1 with wlast on beat 0 → 2 beats still accepted, bresp=10; arburst=00 read → SLVERR on all beats.
- rst pulse during R_BURST beat 2 → all outputs 0 same cycle; after release arready=1, new read returns correct data.
